// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
// Module   : onchip_mem_arbiter
// Purpose  : Two-master (instruction/data) front end for a single-port on-chip
//            memory: window decode, one-access-per-cycle arbitration, and
//            1-cycle read data return.
//            Build option: `define ONCHIP_ARB_RR_EN for round-robin
//            arbitration; otherwise the data master has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [31:0]           i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [31:0]           i_readdata,
    output logic                  i_readdatavalid,

    input  logic [31:0]           d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [3:0]            d_byteenable,
    input  logic [31:0]           d_writedata,
    output logic                  d_waitrequest,
    output logic [31:0]           d_readdata,
    output logic                  d_readdatavalid,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    output logic                  mem_debugaccess,
    input  logic [31:0]           mem_readdata,

    output logic                  err_out_of_range,
    input  logic                  err_clear
);

    localparam int c_TAG_LSB = ADDR_WIDTH + 2;

    logic        w_req_i;
    logic        w_req_d;
    logic        w_hit_i;
    logic        w_hit_d;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_grant_any;
    logic        w_hit_sel;
    logic        w_rd_grant;
    logic [31:0] w_rsp_data;
    logic        w_unused_bits;

    logic        r_rsp_valid;
    logic        r_rsp_owner;   // 1 = data master
    logic        r_rsp_zero;
    logic        r_err;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

    assign w_hit_i = (i_address[31:c_TAG_LSB] == BASE_ADDR[31:c_TAG_LSB]);
    assign w_hit_d = (d_address[31:c_TAG_LSB] == BASE_ADDR[31:c_TAG_LSB]);

    // Byte-offset bits play no part in a word-wide memory.
    assign w_unused_bits = &{1'b0, i_address[1:0], d_address[1:0]};

`ifdef ONCHIP_ARB_RR_EN
    logic r_last_d;   // 1 = data master owned the last granted transfer

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!reset) begin
            if (w_req_i && w_req_d) begin
                if (r_last_d) begin
                    w_grant_i = 1'b1;
                end else begin
                    w_grant_d = 1'b1;
                end
            end else begin
                w_grant_i = w_req_i;
                w_grant_d = w_req_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
        end
    end
`else
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!reset) begin
            w_grant_d = w_req_d;
            w_grant_i = w_req_i & ~w_req_d;
        end
    end
`endif

    assign w_grant_any = w_grant_i | w_grant_d;
    assign w_hit_sel   = w_grant_i ? w_hit_i : w_hit_d;
    // A combined read+write from the data master is a write and yields no response.
    assign w_rd_grant  = w_grant_i | (w_grant_d & ~d_write);

    assign i_waitrequest = reset | (w_req_i & ~w_grant_i);
    assign d_waitrequest = reset | (w_req_d & ~w_grant_d);

    assign mem_address     = w_grant_i ? i_address[ADDR_WIDTH+1:2] : d_address[ADDR_WIDTH+1:2];
    assign mem_byteenable  = w_grant_i ? 4'hF : d_byteenable;
    assign mem_writedata   = d_writedata;
    assign mem_chipselect  = w_grant_any & w_hit_sel;
    assign mem_write       = w_grant_d & d_write & w_hit_sel;
    assign mem_clken       = ~reset;
    assign mem_debugaccess = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_rd_grant;
            r_rsp_owner <= w_grant_d;
            r_rsp_zero  <= ~w_hit_sel;
            if (w_grant_any && !w_hit_sel) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_rsp_data      = r_rsp_zero ? 32'h0 : mem_readdata;
    assign i_readdatavalid = r_rsp_valid & ~r_rsp_owner;
    assign d_readdatavalid = r_rsp_valid &  r_rsp_owner;
    assign i_readdata      = i_readdatavalid ? w_rsp_data : 32'h0;
    assign d_readdata      = d_readdatavalid ? w_rsp_data : 32'h0;

    assign err_out_of_range = r_err;

endmodule

`default_nettype wire
